// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake
// and holds the IF/ID register consumed by decode.
module if_stage #(
   parameter int unsigned         PC_WIDTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   input  logic                imem_ack,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [31:0]         instruction,
   output logic                instr_valid
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_HOLD,
      S_DRAIN
   } state_e;

   state_e              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] pco_q;
   logic [31:0]         instr_q;
   logic                valid_q;
   logic [31:0]         buf_q;

   assign pc_inc = pc_q + PC_WIDTH'(4);

   // Request is gated by reset so memory sees nothing until release.
   assign imem_req    = ~reset & (state_q != S_HOLD);
   assign imem_addr   = pc_q;
   assign pc_out      = pco_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         pco_q   <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         buf_q   <= '0;
      end else if (branch_taken) begin
         pc_q    <= branch_target;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         buf_q   <= '0;
         // An unacked request must still be absorbed before refetching.
         if (state_q != S_HOLD && !imem_ack)
            state_q <= S_DRAIN;
         else
            state_q <= S_FETCH;
      end else begin
         unique case (state_q)
            S_FETCH: begin
               if (imem_ack && !stall) begin
                  pco_q   <= pc_q;
                  instr_q <= imem_rdata;
                  valid_q <= 1'b1;
                  pc_q    <= pc_inc;
               end else if (imem_ack) begin
                  buf_q   <= imem_rdata;
                  state_q <= S_HOLD;
               end else if (!stall) begin
                  instr_q <= NOP_INSTR;
                  valid_q <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  pco_q   <= pc_q;
                  instr_q <= buf_q;
                  valid_q <= 1'b1;
                  pc_q    <= pc_inc;
                  state_q <= S_FETCH;
               end
            end
            S_DRAIN: begin
               instr_q <= NOP_INSTR;
               valid_q <= 1'b0;
               if (imem_ack)
                  state_q <= S_FETCH;
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: transaction-level model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_if_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack = 1'b0;
   logic [7:0]  pc_out;
   logic [31:0] instruction;
   logic        instr_valid;

   int nchk = 0;
   int nerr = 0;
   bit cmp_on = 1'b0;

   if_stage dut (
      .clock         (clock),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ack      (imem_ack),
      .pc_out        (pc_out),
      .instruction   (instruction),
      .instr_valid   (instr_valid)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [7:0] a);
      return 32'hA000_0000 | {24'h0, a};
   endfunction

   assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   // Model: next fetch address, words parked while stalled, and
   // whether the next ack belongs to an abandoned request.
   logic [7:0]  m_pc;
   logic [31:0] m_park[$];
   bit          m_drop;
   logic [7:0]  m_pco;
   logic [31:0] m_ins;
   logic        m_vld;
   bit          m_idle;

   task automatic m_emit(input logic [31:0] w);
      m_pco = m_pc;
      m_ins = w;
      m_vld = 1'b1;
      m_pc  = m_pc + 8'd4;
   endtask

   task automatic m_bubble();
      m_ins = 32'h0000_0013;
      m_vld = 1'b0;
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_pc  = 8'h00;
         m_park.delete();
         m_drop = 1'b0;
         m_pco = 8'h00;
         m_ins = 32'h0000_0013;
         m_vld = 1'b0;
      end else begin
         m_idle = (m_park.size() == 0);
         if (branch_taken) begin
            m_drop = m_idle && !imem_ack;
            m_pc   = branch_target;
            m_park.delete();
            m_bubble();
         end else if (!m_idle) begin
            if (!stall) m_emit(m_park.pop_front());
         end else if (m_drop) begin
            m_bubble();
            if (imem_ack) m_drop = 1'b0;
         end else if (imem_ack) begin
            if (stall) m_park.push_back(mem_word(m_pc));
            else m_emit(mem_word(m_pc));
         end else if (!stall) begin
            m_bubble();
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (cmp_on) begin
         chk("mdl_req", {31'h0, imem_req},
             {31'h0, (!reset && m_park.size() == 0)});
         chk("mdl_addr", {24'h0, imem_addr}, {24'h0, m_pc});
         chk("mdl_pco", {24'h0, pc_out}, {24'h0, m_pco});
         chk("mdl_ins", instruction, m_ins);
         chk("mdl_vld", {31'h0, instr_valid}, {31'h0, m_vld});
      end
   end

   task automatic peek(input string nm, input logic r, input logic [7:0] a,
                       input logic [7:0] p, input logic [31:0] i,
                       input logic v);
      chk({nm, "_req"}, {31'h0, imem_req}, {31'h0, r});
      chk({nm, "_addr"}, {24'h0, imem_addr}, {24'h0, a});
      chk({nm, "_pco"}, {24'h0, pc_out}, {24'h0, p});
      chk({nm, "_ins"}, instruction, i);
      chk({nm, "_vld"}, {31'h0, instr_valid}, {31'h0, v});
   endtask

   task automatic look(input string nm, input logic r, input logic [7:0] a,
                       input logic [7:0] p, input logic [31:0] i,
                       input logic v);
      @(negedge clock);
      peek(nm, r, a, p, i, v);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drv(input logic s, input logic b, input logic [7:0] t,
                      input logic k);
      stall         = s;
      branch_taken  = b;
      branch_target = t;
      imem_ack      = k;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin
      #2 reset = 1'b1;
      cmp_on = 1'b1;
      look("rst", 0, 8'h00, 8'h00, NOP, 0);
      tick();
      // Streaming with ack tied high
      reset = 1'b0;
      drv(0, 0, 8'h00, 1);
      look("s0", 1, 8'h00, 8'h00, NOP, 0);
      tick();
      look("s1", 1, 8'h04, 8'h00, 32'hA000_0000, 1);
      tick();
      look("s2", 1, 8'h08, 8'h04, 32'hA000_0004, 1);
      tick();
      look("s3", 1, 8'h0C, 8'h08, 32'hA000_0008, 1);
      tick();
      // Slow memory at 0x10
      drv(0, 0, 8'h00, 0);
      look("w0", 1, 8'h10, 8'h0C, 32'hA000_000C, 1);
      tick();
      look("w1", 1, 8'h10, 8'h0C, NOP, 0);
      tick();
      drv(0, 0, 8'h00, 1);
      look("w2", 1, 8'h10, 8'h0C, NOP, 0);
      tick();
      look("w3", 1, 8'h14, 8'h10, 32'hA000_0010, 1);
      tick();
      tick();
      tick();
      // Stall in the ack cycle at 0x20
      drv(1, 0, 8'h00, 1);
      look("h0", 1, 8'h20, 8'h1C, 32'hA000_001C, 1);
      tick();
      drv(1, 0, 8'h00, 0);
      look("h1", 0, 8'h20, 8'h1C, 32'hA000_001C, 1);
      tick();
      look("h2", 0, 8'h20, 8'h1C, 32'hA000_001C, 1);
      tick();
      drv(0, 0, 8'h00, 0);
      look("h3", 0, 8'h20, 8'h1C, 32'hA000_001C, 1);
      tick();
      drv(0, 0, 8'h00, 1);
      look("h4", 1, 8'h24, 8'h20, 32'hA000_0020, 1);
      tick();
      tick();
      tick();
      // Redirect to 0x40 while 0x30 is outstanding
      drv(0, 0, 8'h00, 0);
      look("d0", 1, 8'h30, 8'h2C, 32'hA000_002C, 1);
      tick();
      drv(0, 1, 8'h40, 0);
      look("d1", 1, 8'h30, 8'h2C, NOP, 0);
      tick();
      drv(0, 0, 8'h00, 1);
      look("d2", 1, 8'h40, 8'h2C, NOP, 0);
      tick();
      look("d3", 1, 8'h40, 8'h2C, NOP, 0);
      tick();
      look("d4", 1, 8'h44, 8'h40, 32'hA000_0040, 1);
      // Redirect with ack, then wrap at 0xFC
      drv(0, 1, 8'hF4, 1);
      tick();
      drv(0, 0, 8'h00, 1);
      look("f0", 1, 8'hF4, 8'h40, NOP, 0);
      tick();
      tick();
      look("f1", 1, 8'hFC, 8'hF8, 32'hA000_00F8, 1);
      tick();
      look("f2", 1, 8'h00, 8'hFC, 32'hA000_00FC, 1);
      tick();
      look("f3", 1, 8'h04, 8'h00, 32'hA000_0000, 1);
      // Redirect out of HOLD
      drv(1, 0, 8'h00, 1);
      tick();
      drv(1, 1, 8'h80, 0);
      look("b0", 0, 8'h04, 8'h00, 32'hA000_0000, 1);
      tick();
      drv(0, 0, 8'h00, 1);
      look("b1", 1, 8'h80, 8'h00, NOP, 0);
      tick();
      look("b2", 1, 8'h84, 8'h80, 32'hA000_0080, 1);
      // Asynchronous reset in HOLD
      drv(1, 0, 8'h00, 1);
      tick();
      drv(1, 0, 8'h00, 0);
      #2 reset = 1'b1;
      #1 peek("rh", 0, 8'h00, 8'h00, NOP, 0);
      tick();
      reset = 1'b0;
      drv(0, 0, 8'h00, 1);
      look("rh0", 1, 8'h00, 8'h00, NOP, 0);
      tick();
      look("rh1", 1, 8'h04, 8'h00, 32'hA000_0000, 1);
      // Asynchronous reset in DRAIN
      drv(0, 1, 8'h60, 0);
      tick();
      drv(0, 0, 8'h00, 0);
      #2 reset = 1'b1;
      #1 peek("rd", 0, 8'h00, 8'h00, NOP, 0);
      tick();
      reset = 1'b0;
      drv(0, 0, 8'h00, 1);
      look("rd0", 1, 8'h00, 8'h00, NOP, 0);
      tick();
      look("rd1", 1, 8'h04, 8'h00, 32'hA000_0000, 1);
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
